// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC, PC step and FSM state type for the fetch sequencer
package fetch_pkg;

  localparam int              FETCH_PC_W     = 16;
  localparam int              FETCH_INST_W   = 32;
  localparam logic [15:0]     FETCH_RESET_PC = 16'h0000;
  localparam int              FETCH_PC_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating event counter with increment enable
module fetch_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC owner: imem req/ack sequencing, single-entry hold toward decode, redirects.
// FETCH_CTRL_PERF_EN adds saturating stall/redirect performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter int              INST_W   = FETCH_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC),
  parameter int              PC_STEP  = FETCH_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_redirect_cnt
`endif
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  fetch_state_t      state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pend_pc_q;
  logic              imem_req_q;
  logic [PC_W-1:0]   imem_addr_q;
  logic              inst_valid_q;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   inst_pc_q;
  logic [PC_W-1:0]   issue_pc;

  assign issue_pc = redirect_valid ? redirect_pc : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          // A redirect kills the held instruction even while decode is stalled
          if (redirect_valid || (state_q == IDLE) || !stall) begin
            pc_q         <= issue_pc;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            imem_addr_q  <= issue_pc;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (!imem_req_q) begin
            // Line was dropped for one cycle after a discarded response; issue now
            pc_q        <= issue_pc;
            imem_req_q  <= 1'b1;
            imem_addr_q <= issue_pc;
          end else if (imem_ack) begin
            imem_req_q <= 1'b0;
            if (redirect_valid) begin
              pc_q <= redirect_pc;
            end else begin
              inst_q       <= imem_rdata;
              inst_pc_q    <= imem_addr_q;
              inst_valid_q <= 1'b1;
              pc_q         <= imem_addr_q + STEP;
              state_q      <= HOLD;
            end
          end else if (redirect_valid) begin
            pend_pc_q <= redirect_pc;
            state_q   <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            pc_q       <= redirect_valid ? redirect_pc : pend_pc_q;
            state_q    <= REQ;
          end else if (redirect_valid) begin
            pend_pc_q <= redirect_pc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

`ifdef FETCH_CTRL_PERF_EN
  logic stall_evt;

  assign stall_evt = (state_q == HOLD) && stall;

  fetch_perf_cnt #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_evt),
    .cnt_o (perf_stall_cnt)
  );

  fetch_perf_cnt #(.W(16)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (redirect_valid),
    .cnt_o (perf_redirect_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized bench for fetch_ctrl with a transaction-level reference model
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [15:0] inst_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_redirect_cnt;
`endif

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Memory: fixed 2-cycle ack in directed mode, random 0..3 plus stray acks in random mode
  bit mem_random = 0;
  int mem_lat = 2;
  int mem_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst || !imem_req) begin
      mem_cnt    = 0;
      mem_lat    = mem_random ? int'($urandom_range(0, 3)) : 2;
      imem_ack   = mem_random && ($urandom_range(0, 7) == 0);
      imem_rdata = $urandom;
    end else if (mem_cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      mem_cnt    = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mem_cnt++;
    end
  end

  // Reference model: tracks which PC the next request must use, whether the outstanding
  // request is still wanted, and what decode must be shown.
  bit          m_holding;
  logic [31:0] m_hold_inst;
  logic [15:0] m_hold_pc;
  logic [15:0] m_exp_pc;
  bit          m_live;
  bit          m_prev_req;
  bit          m_prev_hs;
  logic [15:0] m_prev_addr;
  int          m_gap;
  int          m_delivered = 0;
  logic [15:0] m_stall_cnt;
  logic [15:0] m_redir_cnt;
  bit          m_new_req;
  bit          m_hold_nxt;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, 16'h0000);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 16'h0000);
      m_holding   = 0;
      m_live      = 0;
      m_exp_pc    = 16'h0000;
      m_prev_req  = 0;
      m_prev_hs   = 0;
      m_prev_addr = 16'h0000;
      m_gap       = 0;
      m_stall_cnt = 16'h0000;
      m_redir_cnt = 16'h0000;
    end else begin
      if (m_prev_req && !m_prev_hs) begin
        check("hs_req_held", imem_req, 1'b1);
        check("hs_addr_held", imem_addr, m_prev_addr);
      end
      if (m_prev_hs) check("hs_req_drop", imem_req, 1'b0);
      m_new_req = imem_req && !(m_prev_req && !m_prev_hs);
      if (m_new_req) begin
        check("req_addr", imem_addr, m_exp_pc);
        m_live = 1;
      end
      check("valid", inst_valid, m_holding);
      if (m_holding) begin
        check("hold_inst", inst, m_hold_inst);
        check("hold_pc", inst_pc, m_hold_pc);
        check("no_prefetch", imem_req, 1'b0);
      end
      m_gap = (!imem_req && !m_holding) ? m_gap + 1 : 0;
      if (m_gap > 2) check("req_gap", m_gap, 2);

      m_hold_nxt = m_holding && !redirect_valid && stall;
      if (imem_req && imem_ack) begin
        if (m_live && !redirect_valid) begin
          m_hold_nxt  = 1;
          m_hold_inst = imem_rdata;
          m_hold_pc   = imem_addr;
          m_exp_pc    = imem_addr + 16'd4;
          m_delivered++;
        end
        m_live = 0;
      end
      if (redirect_valid) begin
        m_exp_pc = redirect_pc;
        m_live   = 0;
        if (m_redir_cnt != 16'hFFFF) m_redir_cnt++;
      end
      if (m_holding && stall && (m_stall_cnt != 16'hFFFF)) m_stall_cnt++;
      m_holding   = m_hold_nxt;
      m_prev_req  = imem_req;
      m_prev_hs   = imem_req && imem_ack;
      m_prev_addr = imem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input string tag, input logic [15:0] a);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == a) found = 1;
      else step();
    end
    check(tag, found, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (inst_valid) found = 1;
      else step();
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (3) step();
    check("reset_addr", imem_addr, 16'h0000);

    // Sequential fetch with 2-cycle memory
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", imem_req, 1'b0);
    step();
    check("t1_req0", imem_req, 1'b1);
    check("t1_addr0", imem_addr, 16'h0000);
    repeat (3) step();
    check("t1_valid0", inst_valid, 1'b1);
    check("t1_pc0", inst_pc, 16'h0000);
    check("t1_inst0", inst, mem_word(16'h0000));
    step();
    check("t1_valid_1cyc", inst_valid, 1'b0);
    check("t1_addr4", imem_addr, 16'h0004);
    repeat (3) step();
    check("t2_hold_pc4", inst_pc, 16'h0004);

    // Stall three cycles in HOLD
    stall = 1'b1;
    repeat (3) step();
    check("t2_still_valid", inst_valid, 1'b1);
    check("t2_still_pc", inst_pc, 16'h0004);
    check("t2_no_req", imem_req, 1'b0);
    stall = 1'b0;
    step();
    check("t2_req8", imem_req, 1'b1);
    check("t2_addr8", imem_addr, 16'h0008);

    // Redirect during an outstanding request
    redirect_valid = 1'b1; redirect_pc = 16'h1010;
    step();
    redirect_valid = 1'b0;
    check("t3_drop_addr", imem_addr, 16'h0008);
    step();
    check("t3_ack_req", imem_req, 1'b1);
    step();
    check("t3_req_low", imem_req, 1'b0);
    check("t3_no_valid", inst_valid, 1'b0);
    step();
    check("t3_addr1010", imem_addr, 16'h1010);
    repeat (3) step();
    check("t3_pc1010", inst_pc, 16'h1010);
    check("t3_inst1010", inst, mem_word(16'h1010));
    step();
    check("t3_addr1014", imem_addr, 16'h1014);

    // Redirect in the ack cycle, then redirect while stalled in HOLD
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 16'h1011;
    step();
    redirect_valid = 1'b0;
    check("t4_no_valid", inst_valid, 1'b0);
    step();
    check("t4_addr1011", imem_addr, 16'h1011);
    repeat (3) step();
    check("t4_pc1011", inst_pc, 16'h1011);
    stall = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h1111;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("t4_killed", inst_valid, 1'b0);
    check("t4_req1111", imem_req, 1'b1);
    check("t4_addr1111", imem_addr, 16'h1111);

    // PC wrap and reset in the middle of a request
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    step();
    redirect_valid = 1'b0;
    wait_req("t5_reqFFFC", 16'hFFFC);
    step();
    wait_req("t5_wrap0000", 16'h0000);
    step();
    wait_req("t5_req0004", 16'h0004);
    rst = 1'b1;
    #1;
    check("t5_rst_req", imem_req, 1'b0);
    check("t5_rst_addr", imem_addr, 16'h0000);
    step();
    rst = 1'b0;
    step();
    check("t5_restart_req", imem_req, 1'b1);
    check("t5_restart_addr", imem_addr, 16'h0000);

    // Randomized traffic against the reference model
    mem_random = 1;
    for (int i = 0; i < 4000; i++) begin
      stall          = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                   : 16'($urandom);
      rst            = ($urandom_range(0, 599) == 0);
      step();
    end
    stall = 1'b0; redirect_valid = 1'b0; rst = 1'b0;
    check("rand_progress", m_delivered > 200, 1'b1);
`ifdef FETCH_CTRL_PERF_EN
    check("rand_perf_stall", perf_stall_cnt, m_stall_cnt);
    check("rand_perf_redir", perf_redirect_cnt, m_redir_cnt);

    mem_random = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    wait_valid("p_valid");
    stall = 1'b1;
    repeat (5) step();
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h2000;
    repeat (2) step();
    redirect_valid = 1'b0;
    step();
    check("perf_stall5", perf_stall_cnt, 16'd5);
    check("perf_redir2", perf_redirect_cnt, 16'd2);
    check("perf_stall_model", perf_stall_cnt, m_stall_cnt);

    force dut.u_stall_cnt.cnt_q = 16'hFFFF;
    step();
    release dut.u_stall_cnt.cnt_q;
    m_stall_cnt = 16'hFFFF;
    wait_valid("p_valid2");
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    step();
    check("perf_saturate", perf_stall_cnt, 16'hFFFF);
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
